// File: rtl/au_seq_if.sv
// Handshake and operand/result bundle for the chunked arithmetic unit.
// master drives requests and consumes results; slave is the unit itself.
interface au_seq_if #(
    parameter int unsigned W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s0;
    logic         s1;
    logic         cin;
    logic         use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] acc;

    modport master (
        output in_valid, x, y, s0, s1, cin, use_acc, out_ready,
        input  in_ready, out_valid, f, cout, ovf, zero, acc
    );

    modport slave (
        input  in_valid, x, y, s0, s1, cin, use_acc, out_ready,
        output in_ready, out_valid, f, cout, ovf, zero, acc
    );
endinterface

// File: rtl/au_seq.sv
// Multi-cycle W-bit arithmetic unit: one CW-bit adder chunk per clock, accumulator
// operand source, registered result and flags behind valid/ready handshakes.
module au_seq #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 4
) (
    input logic    clk,
    input logic    rst,
    au_seq_if.slave bus
);
    localparam int unsigned NCH = W / CW;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {st_idle, st_busy, st_done} state_t;

    state_t        state;
    logic [W-1:0]  a_q, b_q, sum_q, acc_q, f_q;
    logic          carry_q, cout_q, ovf_q, zero_q, out_valid_q;
    logic [IW-1:0] idx_q;

    logic [2:0]    op;
    logic [W-1:0]  opa, a_in, b_in;
    logic          c_in;

    always_comb begin
        op   = {bus.s1, bus.s0, bus.cin};
        opa  = bus.use_acc ? acc_q : bus.x;
        a_in = opa;
        b_in = '0;
        c_in = 1'b0;
        case (op)
            3'b000: ;
            3'b001: c_in = 1'b1;
            3'b010: b_in = bus.y;
            3'b011: begin b_in = bus.y;  c_in = 1'b1; end
            3'b100: begin b_in = ~bus.y; c_in = 1'b1; end
            3'b101: b_in = ~bus.y;
            3'b110: begin b_in = {{(W-1){1'b1}}, 1'b0}; c_in = 1'b1; end
            3'b111: begin a_in = '0; b_in = bus.y; end
            default: ;
        endcase
    end

    // Operands shift right each chunk, so the active chunk is always in the low CW bits
    // and the sum is assembled from the top down.
    logic [CW:0]  ch;
    logic [W-1:0] ch_ext, sum_next;
    logic         msb_cin;

    always_comb begin
        ch       = {1'b0, a_q[CW-1:0]} + {1'b0, b_q[CW-1:0]} + {{CW{1'b0}}, carry_q};
        ch_ext   = '0;
        ch_ext[CW-1:0] = ch[CW-1:0];
        sum_next = (sum_q >> CW) | (ch_ext << (W - CW));
        msb_cin  = a_q[CW-1] ^ b_q[CW-1] ^ ch[CW-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= st_idle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (bus.in_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        state   <= st_busy;
                    end
                end
                st_busy: begin
                    a_q     <= a_q >> CW;
                    b_q     <= b_q >> CW;
                    carry_q <= ch[CW];
                    sum_q   <= sum_next;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IW'(NCH - 1)) begin
                        f_q         <= sum_next;
                        cout_q      <= ch[CW];
                        ovf_q       <= msb_cin ^ ch[CW];
                        zero_q      <= (sum_next == '0);
                        acc_q       <= sum_next;
                        out_valid_q <= 1'b1;
                        state       <= st_done;
                    end
                end
                st_done: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign bus.in_ready  = (state == st_idle);
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.acc       = acc_q;
endmodule
